// File: rtl/mha_pkg.sv
// Shared types and defaults for the systolic array edge feeder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mha_pkg;

    // Default element width: Q2.13 signed fixed point.
    localparam int D_W_DEF = 16;

    typedef logic signed [D_W_DEF-1:0] q2_13_t;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        STREAM,
        FLUSH,
        DONE
    } feeder_state_e;

endpackage

// File: rtl/skew_delay_line.sv
// One feeder lane: DEPTH+1 register stages carrying a valid bit and a data word.
// Latency: DEPTH+1 cycles from I_VLD/I_DATA to O_VLD/O_DATA.
// Backpressure: none; I_EN=0 freezes every stage (valid and data).
// Ports: I_CLK, I_SYNC_RST (sync, active-high), I_EN, I_VLD/I_DATA in, O_VLD/O_DATA out.
module skew_delay_line
    import mha_pkg::*;
#(
    parameter int D_W   = D_W_DEF,
    parameter int DEPTH = 0
) (
    input  logic           I_CLK,
    input  logic           I_SYNC_RST,
    input  logic           I_EN,
    input  logic           I_VLD,
    input  logic [D_W-1:0] I_DATA,
    output logic           O_VLD,
    output logic [D_W-1:0] O_DATA
);

    logic [DEPTH:0] vld_q;
    logic [D_W-1:0] dat_q [DEPTH+1];

    // Valid always shifts; a data stage only loads when the word arriving at it
    // is valid, so bubbles leave the previous operand in place (PE hold semantics).
    always_ff @(posedge I_CLK) begin
        if (I_SYNC_RST) begin
            vld_q <= '0;
            for (int k = 0; k <= DEPTH; k++) begin
                dat_q[k] <= '0;
            end
        end else if (I_EN) begin
            vld_q[0] <= I_VLD;
            if (I_VLD) begin
                dat_q[0] <= I_DATA;
            end
            for (int k = 1; k <= DEPTH; k++) begin
                vld_q[k] <= vld_q[k-1];
                if (vld_q[k-1]) begin
                    dat_q[k] <= dat_q[k-1];
                end
            end
        end
    end

    assign O_VLD  = vld_q[DEPTH];
    assign O_DATA = dat_q[DEPTH];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Edge feeder for the PE array: accepts N-lane row beats and emits them skewed (lane i delayed i).
// Latency: beat accepted in cycle t shows on lane i in cycle t+1+i; O_DONE in cycle last+N+1.
// Backpressure: O_RDY only high in STREAM; optional I_STALL (FEEDER_STALL_EN) freezes everything.
// Ports: I_CLK, I_SYNC_RST, I_VLD/O_RDY/I_DATA/I_LAST in-beat, O_VLD/O_DATA skewed lanes,
//        O_ACC_CLR_N array accumulator clear (active-low), O_DONE and O_OVF single-cycle pulses.
module systolic_skew_feeder
    import mha_pkg::*;
#(
    parameter int D_W   = D_W_DEF,
    parameter int N     = 8,
    parameter int MAX_K = 64
) (
    input  logic             I_CLK,
    input  logic             I_SYNC_RST,
    input  logic             I_VLD,
    output logic             O_RDY,
    input  logic [N*D_W-1:0] I_DATA,
    input  logic             I_LAST,
    output logic [N-1:0]     O_VLD,
    output logic [N*D_W-1:0] O_DATA,
    output logic             O_ACC_CLR_N,
    output logic             O_DONE,
`ifdef FEEDER_STALL_EN
    output logic             O_OVF,
    input  logic             I_STALL
`else
    output logic             O_OVF
`endif
);

    localparam int BCW = $clog2(MAX_K + 1);
    localparam int FCW = $clog2(N + 1);

    logic stall;
`ifdef FEEDER_STALL_EN
    assign stall = I_STALL;
`else
    assign stall = 1'b0;
`endif

    feeder_state_e  state_q, state_nxt;
    logic [BCW-1:0] bcnt_q, bcnt_nxt;
    logic [FCW-1:0] fcnt_q, fcnt_nxt;
    logic           ovf_nxt;
    logic           rdy_q, clr_n_q, done_q, ovf_q;
    logic           accept;

    assign accept = I_VLD & rdy_q & ~stall;

    always_comb begin
        state_nxt = state_q;
        bcnt_nxt  = bcnt_q;
        fcnt_nxt  = fcnt_q;
        ovf_nxt   = 1'b0;
        case (state_q)
            IDLE: begin
                // The beat stays upstream; it is taken in the first STREAM cycle.
                if (I_VLD) begin
                    state_nxt = CLR;
                end
            end
            CLR: begin
                bcnt_nxt  = '0;
                state_nxt = STREAM;
            end
            STREAM: begin
                if (accept) begin
                    bcnt_nxt = bcnt_q + 1'b1;
                    if (I_LAST) begin
                        state_nxt = FLUSH;
                        fcnt_nxt  = '0;
                    end else if (bcnt_q == BCW'(MAX_K - 1)) begin
                        // Tile ran to MAX_K beats: close it as if this beat were last.
                        state_nxt = FLUSH;
                        fcnt_nxt  = '0;
                        ovf_nxt   = 1'b1;
                    end
                end
            end
            FLUSH: begin
                // N cycles lets the final beat clear lane N-1.
                if (fcnt_q == FCW'(N - 1)) begin
                    state_nxt = DONE;
                end else begin
                    fcnt_nxt = fcnt_q + 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge I_CLK) begin
        if (I_SYNC_RST) begin
            state_q <= IDLE;
            bcnt_q  <= '0;
            fcnt_q  <= '0;
            rdy_q   <= 1'b0;
            clr_n_q <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (!stall) begin
            state_q <= state_nxt;
            bcnt_q  <= bcnt_nxt;
            fcnt_q  <= fcnt_nxt;
            rdy_q   <= (state_nxt == STREAM);
            clr_n_q <= (state_nxt != CLR);
            done_q  <= (state_nxt == DONE);
            ovf_q   <= ovf_nxt;
        end
    end

    // Pulses are masked while frozen so each is seen for exactly one unstalled cycle.
    assign O_RDY       = rdy_q & ~stall;
    assign O_ACC_CLR_N = clr_n_q;
    assign O_DONE      = done_q & ~stall;
    assign O_OVF       = ovf_q & ~stall;

    logic [N-1:0] lane_vld;

    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_delay_line #(
            .D_W   (D_W),
            .DEPTH (i)
        ) u_line (
            .I_CLK      (I_CLK),
            .I_SYNC_RST (I_SYNC_RST),
            .I_EN       (~stall),
            .I_VLD      (accept),
            .I_DATA     (I_DATA[i*D_W +: D_W]),
            .O_VLD      (lane_vld[i]),
            .O_DATA     (O_DATA[i*D_W +: D_W])
        );
        assign O_VLD[i] = lane_vld[i] & ~stall;
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder with N=4, MAX_K=4.
// Latency: n/a.
// Backpressure: n/a.
module tb_systolic_skew_feeder;

    localparam int D_W   = 16;
    localparam int N     = 4;
    localparam int MAX_K = 4;

    logic             I_CLK = 1'b0;
    logic             I_SYNC_RST;
    logic             I_VLD;
    logic             O_RDY;
    logic [N*D_W-1:0] I_DATA;
    logic             I_LAST;
    logic [N-1:0]     O_VLD;
    logic [N*D_W-1:0] O_DATA;
    logic             O_ACC_CLR_N;
    logic             O_DONE;
    logic             O_OVF;

    int checks = 0;
    int errors = 0;

    systolic_skew_feeder #(
        .D_W   (D_W),
        .N     (N),
        .MAX_K (MAX_K)
    ) dut (
        .I_CLK       (I_CLK),
        .I_SYNC_RST  (I_SYNC_RST),
        .I_VLD       (I_VLD),
        .O_RDY       (O_RDY),
        .I_DATA      (I_DATA),
        .I_LAST      (I_LAST),
        .O_VLD       (O_VLD),
        .O_DATA      (O_DATA),
        .O_ACC_CLR_N (O_ACC_CLR_N),
        .O_DONE      (O_DONE),
        .O_OVF       (O_OVF)
    );

    always #5 I_CLK = ~I_CLK;

    // Beat b carries 16'(b*256 + lane) on every lane; beat id 0 stands for an all-zero word.
    function automatic logic [N*D_W-1:0] beat_bus(input int b0, input int b1, input int b2, input int b3);
        int bs [N];
        logic [N*D_W-1:0] v;
        bs = '{b0, b1, b2, b3};
        v  = '0;
        for (int i = 0; i < N; i++) begin
            v[i*D_W +: D_W] = (bs[i] == 0) ? 16'h0 : 16'(bs[i] * 256 + i);
        end
        return v;
    endfunction

    task automatic step();
        @(posedge I_CLK);
        #1;
    endtask

    task automatic put(input int b, input logic last);
        I_VLD  = 1'b1;
        I_LAST = last;
        I_DATA = beat_bus(b, b, b, b);
    endtask

    task automatic idle_in();
        I_VLD  = 1'b0;
        I_LAST = 1'b0;
        I_DATA = '0;
    endtask

    task automatic chk(input string tag, input logic [N-1:0] ev,
                       input int b0, input int b1, input int b2, input int b3,
                       input logic er, input logic ec, input logic ed, input logic eo);
        logic [N*D_W-1:0] edat;
        edat = beat_bus(b0, b1, b2, b3);
        checks++;
        assert (O_VLD === ev) else begin
            errors++;
            $error("FAIL %s O_VLD: observed %b expected %b", tag, O_VLD, ev);
        end
        checks++;
        assert (O_DATA === edat) else begin
            errors++;
            $error("FAIL %s O_DATA: observed %h expected %h", tag, O_DATA, edat);
        end
        checks++;
        assert (O_RDY === er) else begin
            errors++;
            $error("FAIL %s O_RDY: observed %b expected %b", tag, O_RDY, er);
        end
        checks++;
        assert (O_ACC_CLR_N === ec) else begin
            errors++;
            $error("FAIL %s O_ACC_CLR_N: observed %b expected %b", tag, O_ACC_CLR_N, ec);
        end
        checks++;
        assert (O_DONE === ed) else begin
            errors++;
            $error("FAIL %s O_DONE: observed %b expected %b", tag, O_DONE, ed);
        end
        checks++;
        assert (O_OVF === eo) else begin
            errors++;
            $error("FAIL %s O_OVF: observed %b expected %b", tag, O_OVF, eo);
        end
    endtask

    initial begin
        I_SYNC_RST = 1'b1;
        idle_in();
        step();
        step();
        chk("reset", 4'b0000, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        I_SYNC_RST = 1'b0;
        step();
        chk("idle", 4'b0000, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Tile 1: beats 1,2,3, last on 3.
        put(1, 1'b0);
        step(); chk("t1_clr",    4'b0000, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(); chk("t1_stream", 4'b0000, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(); chk("t1_s1",     4'b0001, 1, 0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        put(2, 1'b0);
        step(); chk("t1_s2",     4'b0011, 2, 1, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        put(3, 1'b1);
        step(); chk("t1_s3",     4'b0111, 3, 2, 1, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle_in();
        step(); chk("t1_s4",     4'b1110, 3, 3, 2, 1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(); chk("t1_s5",     4'b1100, 3, 3, 3, 2, 1'b0, 1'b1, 1'b0, 1'b0);
        step(); chk("t1_s6",     4'b1000, 3, 3, 3, 3, 1'b0, 1'b1, 1'b0, 1'b0);
        step(); chk("t1_done",   4'b0000, 3, 3, 3, 3, 1'b0, 1'b1, 1'b1, 1'b0);
        step(); chk("t1_idle",   4'b0000, 3, 3, 3, 3, 1'b0, 1'b1, 1'b0, 1'b0);

        // Tile 2: A=4, bubble (with a stray I_LAST that must be ignored), B=5 last.
        put(4, 1'b0);
        step(); chk("t2_clr",    4'b0000, 3, 3, 3, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        step(); chk("t2_stream", 4'b0000, 3, 3, 3, 3, 1'b1, 1'b1, 1'b0, 1'b0);
        step(); chk("t2_u1",     4'b0001, 4, 3, 3, 3, 1'b1, 1'b1, 1'b0, 1'b0);
        I_VLD  = 1'b0;
        I_LAST = 1'b1;
        step(); chk("t2_u2",     4'b0010, 4, 4, 3, 3, 1'b1, 1'b1, 1'b0, 1'b0);
        put(5, 1'b1);
        step(); chk("t2_u3",     4'b0101, 5, 4, 4, 3, 1'b0, 1'b1, 1'b0, 1'b0);
        idle_in();
        step(); chk("t2_u4",     4'b1010, 5, 5, 4, 4, 1'b0, 1'b1, 1'b0, 1'b0);
        step(); chk("t2_u5",     4'b0100, 5, 5, 5, 4, 1'b0, 1'b1, 1'b0, 1'b0);
        step(); chk("t2_u6",     4'b1000, 5, 5, 5, 5, 1'b0, 1'b1, 1'b0, 1'b0);
        step(); chk("t2_done",   4'b0000, 5, 5, 5, 5, 1'b0, 1'b1, 1'b1, 1'b0);
        step();

        // Tile 3: single beat 6 with I_LAST on the first beat.
        put(6, 1'b1);
        step(); chk("t3_clr",    4'b0000, 5, 5, 5, 5, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        step(); chk("t3_w1",     4'b0001, 6, 5, 5, 5, 1'b0, 1'b1, 1'b0, 1'b0);
        idle_in();
        step(); chk("t3_w2",     4'b0010, 6, 6, 5, 5, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        step(); chk("t3_w4",     4'b1000, 6, 6, 6, 6, 1'b0, 1'b1, 1'b0, 1'b0);
        step(); chk("t3_done",   4'b0000, 6, 6, 6, 6, 1'b0, 1'b1, 1'b1, 1'b0);
        step();

        // Tile 4: beats 7..10 without I_LAST; MAX_K=4 closes the tile with O_OVF.
        put(7, 1'b0);
        step();
        step();
        step(); chk("t4_x1",     4'b0001, 7, 6, 6, 6, 1'b1, 1'b1, 1'b0, 1'b0);
        put(8, 1'b0);
        step(); chk("t4_x2",     4'b0011, 8, 7, 6, 6, 1'b1, 1'b1, 1'b0, 1'b0);
        put(9, 1'b0);
        step(); chk("t4_x3",     4'b0111, 9, 8, 7, 6, 1'b1, 1'b1, 1'b0, 1'b0);
        put(10, 1'b0);
        step(); chk("t4_ovf",    4'b1111, 10, 9, 8, 7, 1'b0, 1'b1, 1'b0, 1'b1);
        idle_in();
        step(); chk("t4_x5",     4'b1110, 10, 10, 9, 8, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        step(); chk("t4_x7",     4'b1000, 10, 10, 10, 10, 1'b0, 1'b1, 1'b0, 1'b0);
        step(); chk("t4_done",   4'b0000, 10, 10, 10, 10, 1'b0, 1'b1, 1'b1, 1'b0);
        step();

        // Tile 5: reset in the middle of STREAM, then a fresh tile.
        put(12, 1'b0);
        step();
        step();
        step(); chk("t5_y1",     4'b0001, 12, 10, 10, 10, 1'b1, 1'b1, 1'b0, 1'b0);
        put(13, 1'b0);
        step(); chk("t5_y2",     4'b0011, 13, 12, 10, 10, 1'b1, 1'b1, 1'b0, 1'b0);
        I_SYNC_RST = 1'b1;
        step(); chk("t5_rst",    4'b0000, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        I_SYNC_RST = 1'b0;
        idle_in();
        step(); chk("t5_idle",   4'b0000, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        put(14, 1'b1);
        step(); chk("t5_clr",    4'b0000, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(); chk("t5_stream", 4'b0000, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(); chk("t5_z4",     4'b0001, 14, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle_in();
        step(); chk("t5_z5",     4'b0010, 14, 14, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        step();
        step(); chk("t5_done",   4'b0000, 14, 14, 14, 14, 1'b0, 1'b1, 1'b1, 1'b0);
        step(); chk("t5_end",    4'b0000, 14, 14, 14, 14, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
